// File: rtl/tm_pkg.sv
// Shared definitions for the TM-style 7-segment bus receiver.
package tm_pkg;

    // Display RAM size used by the receiver unless overridden.
    localparam int unsigned DEF_NUM_DIGITS = 9;

    // Command class, taken from bits [7:6] of the first byte of a frame.
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit of a data command that selects fixed addressing (1) or auto-increment (0).
    localparam int unsigned FIXED_BIT = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2,
        StSkip = 2'd3
    } state_t;

endpackage

// File: rtl/tm_sync.sv
// Multi-flop synchronizer with rising/falling edge pulses on the synchronized value.
// All flops reset to 1 so an idle bus produces no edges after reset.
module tm_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // stg_q[STAGES-1] is the synchronized level; stg_q[STAGES] is its previous value.
    logic [STAGES:0] stg_q;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_q <= '1;
        end else begin
            stg_q <= {stg_q[STAGES-1:0], din};
        end
    end

    assign dout = stg_q[STAGES-1];
    assign rise = stg_q[STAGES-1] & ~stg_q[STAGES];
    assign fall = ~stg_q[STAGES-1] & stg_q[STAGES];

endmodule

// File: rtl/tm_7seg9_rx.sv
// Receiver for a two-wire TM-style display bus: decodes data, display-control and
// address commands and maintains the digit segment RAM and brightness/enable registers.
module tm_7seg9_rx
    import tm_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tm_clk,
    input  logic                    tm_din,
    output logic [8*NUM_DIGITS-1:0] led_data_packed,
    output logic [2:0]              level,
    output logic                    on,
    output logic                    frame_done,
    output logic                    err
);

    logic clk_s, clk_rise, clk_fall;
    logic din_s, din_rise, din_fall;
    logic start, stop;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       bit_q;
    logic       pend_q;
    logic       byte_rdy_q;
    logic [3:0] addr_q;
    logic       fixed_q;

    tm_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_clk (
        .clk  (clk),
        .rst  (rst),
        .din  (tm_clk),
        .dout (clk_s),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    tm_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_din (
        .clk  (clk),
        .rst  (rst),
        .din  (tm_din),
        .dout (din_s),
        .rise (din_rise),
        .fall (din_fall)
    );

    assign start = din_fall & clk_s;
    assign stop  = din_rise & clk_s;

    // Frame FSM: bit assembly, command decode, RAM and control register updates.
    // A bit is sampled on tm_clk rise but only committed on the following fall: the
    // clock rise that precedes a STOP must not be counted as a data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            bit_q           <= 1'b0;
            pend_q          <= 1'b0;
            byte_rdy_q      <= 1'b0;
            addr_q          <= '0;
            fixed_q         <= 1'b0;
            led_data_packed <= '0;
            level           <= '0;
            on              <= 1'b0;
            frame_done      <= 1'b0;
            err             <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            byte_rdy_q <= 1'b0;
            if (stop) begin
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                pend_q     <= 1'b0;
                frame_done <= 1'b1;
                if (bit_cnt_q != 3'd0) begin
                    err <= 1'b1;
                end
            end else if (start) begin
                // Restart discards any partial byte silently.
                state_q   <= StCmd;
                bit_cnt_q <= '0;
                pend_q    <= 1'b0;
            end else begin
                if (clk_rise && state_q != StIdle) begin
                    bit_q  <= din_s;
                    pend_q <= 1'b1;
                end
                if (clk_fall && pend_q) begin
                    pend_q    <= 1'b0;
                    shreg_q   <= {bit_q, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_rdy_q <= 1'b1;
                    end
                end
                if (byte_rdy_q) begin
                    unique case (state_q)
                        StCmd: begin
                            case (shreg_q[7:6])
                                CMD_DATA: begin
                                    fixed_q <= shreg_q[FIXED_BIT];
                                    state_q <= StSkip;
                                end
                                CMD_DISP: begin
                                    on      <= shreg_q[3];
                                    level   <= shreg_q[2:0];
                                    state_q <= StSkip;
                                end
                                CMD_ADDR: begin
                                    addr_q  <= shreg_q[3:0];
                                    state_q <= StData;
                                end
                                default: begin
                                    err     <= 1'b1;
                                    state_q <= StSkip;
                                end
                            endcase
                        end
                        StData: begin
                            // Addresses beyond the RAM simply match no digit.
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (int'(addr_q) == i) begin
                                    led_data_packed[8*i +: 8] <= shreg_q;
                                end
                            end
                            if (!fixed_q) begin
                                addr_q <= addr_q + 4'd1;
                            end
                        end
                        StSkip: begin
                            err <= 1'b1;
                        end
                        StIdle: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tm_7seg9_rx.sv
`timescale 1ns/1ps
module tb_tm_7seg9_rx;

    localparam int N = 9;
    localparam int T = 400;  // tm_clk high phase; low phase is also T

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           tm_clk = 1'b1;
    logic           tm_din = 1'b1;
    logic [8*N-1:0] led_data_packed;
    logic [2:0]     level;
    logic           on;
    logic           frame_done;
    logic           err;

    tm_7seg9_rx #(
        .NUM_DIGITS  (N),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tm_clk          (tm_clk),
        .tm_din          (tm_din),
        .led_data_packed (led_data_packed),
        .level           (level),
        .on              (on),
        .frame_done      (frame_done),
        .err             (err)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the visible state.
    logic [7:0] m_ram [N];
    logic [2:0] m_level;
    logic       m_on;
    logic       m_fixed;
    int         m_addr;
    int         exp_err;

    logic [7:0] frame_q [$];
    logic       check_en = 1'b0;
    int         err_seen = 0;
    int         fd_seen  = 0;

    function automatic logic [8*N-1:0] model_packed();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = m_ram[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ram[i] = 8'h00;
        m_level = 3'd0;
        m_on    = 1'b0;
        m_fixed = 1'b0;
        m_addr  = 0;
    endtask

    // Apply a whole frame (complete bytes in frame_q, then `partial` loose bits).
    task automatic model_frame(input int partial);
        logic [7:0] c;
        exp_err = (partial != 0) ? 1 : 0;
        if (frame_q.size() == 0) return;
        c = frame_q[0];
        case (c[7:6])
            2'b01: m_fixed = c[2];
            2'b10: begin
                m_on    = c[3];
                m_level = c[2:0];
            end
            2'b11: m_addr = int'(c[3:0]);
            default: exp_err++;
        endcase
        for (int i = 1; i < frame_q.size(); i++) begin
            if (c[7:6] == 2'b11) begin
                if (m_addr < N) m_ram[m_addr] = frame_q[i];
                if (!m_fixed) m_addr = (m_addr + 1) % 16;
            end else begin
                exp_err++;
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: pulse counting, and full state comparison while the bus is quiet.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (err) err_seen++;
                if (frame_done) fd_seen++;
            end
            if (check_en) begin
                checks++;
                if (led_data_packed !== model_packed() || level !== m_level || on !== m_on ||
                    err !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL quiet_state @%0t: got ram=%h level=%0d on=%0b err=%0b fd=%0b, expected ram=%h level=%0d on=%0b err=0 fd=0",
                             $time, led_data_packed, level, on, err, frame_done,
                             model_packed(), m_level, m_on);
                end
            end
        end
    end

    task automatic bus_start();
        #(T/2) tm_din = 1'b1;
        #(T/2) tm_clk = 1'b1;
        #T     tm_din = 1'b0;
        #T     tm_clk = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        #(T/2) tm_din = b;
        #(T/2) tm_clk = 1'b1;
        #T     tm_clk = 1'b0;
    endtask

    task automatic bus_stop();
        #(T/2) tm_din = 1'b0;
        #(T/2) tm_clk = 1'b1;
        #T     tm_din = 1'b1;
        #T;
    endtask

    task automatic run_frame(input int partial);
        check_en = 1'b0;
        err_seen = 0;
        fd_seen  = 0;
        bus_start();
        for (int i = 0; i < frame_q.size(); i++) begin
            for (int k = 0; k < 8; k++) bus_bit(frame_q[i][k]);
        end
        for (int k = 0; k < partial; k++) bus_bit(1'((k + 1) & 1));
        bus_stop();
        repeat (10) @(posedge clk);
        model_frame(partial);
        check_val("err_pulses", err_seen, exp_err);
        check_val("frame_done_pulses", fd_seen, 1);
        check_en = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        logic [7:0] b40;
        model_reset();
        #1 rst = 1'b0;
        #20 check_en = 1'b1;
        repeat (4) @(posedge clk);
        check_val("reset_ram_lit", led_data_packed[31:0], 32'h0);
        #10 rst = 1'b1;
        repeat (4) @(posedge clk);

        // Auto-increment fill of all nine digits.
        frame_q = '{8'h40};
        run_frame(0);
        frame_q = '{8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
        run_frame(0);
        check_val("digit0_lit", led_data_packed[7:0], 8'h3F);
        check_val("digit1_lit", led_data_packed[15:8], 8'h06);
        check_val("digit8_lit", led_data_packed[71:64], 8'h7F);

        // Fixed address: both data bytes land on digit 3.
        frame_q = '{8'h44};
        run_frame(0);
        frame_q = '{8'hC3, 8'h11, 8'h22};
        run_frame(0);
        check_val("fixed_digit3_lit", led_data_packed[31:24], 8'h22);
        check_val("fixed_digit4_lit", led_data_packed[39:32], 8'h66);

        // Display control.
        frame_q = '{8'h8C};
        run_frame(0);
        check_val("on_lit", on, 1);
        check_val("level_lit", level, 4);
        frame_q = '{8'h80};
        run_frame(0);
        check_val("off_lit", on, 0);
        check_val("level0_lit", level, 0);

        // Address wrap 15 -> 0; byte for address 15 is dropped.
        frame_q = '{8'h40};
        run_frame(0);
        frame_q = '{8'hCF, 8'hAA, 8'h55};
        run_frame(0);
        check_val("wrap_digit0_lit", led_data_packed[7:0], 8'h55);

        // Extra byte after a data command is an error.
        frame_q = '{8'h40, 8'h12};
        run_frame(0);
        check_val("skip_err_lit", err_seen, 1);

        // Invalid command class.
        frame_q = '{8'h00};
        run_frame(0);
        check_val("invalid_err_lit", err_seen, 1);

        // STOP after 4 bits of a data byte.
        frame_q = '{8'hC1};
        run_frame(4);
        check_val("partial_err_lit", err_seen, 1);
        check_val("partial_digit1_lit", led_data_packed[15:8], 8'h06);

        // Reset in the middle of a byte, then a fresh frame.
        check_en = 1'b0;
        b40 = 8'h40;
        bus_start();
        for (int k = 0; k < 8; k++) bus_bit(b40[k]);
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_bit(1'b1);
        #(T/2) rst = 1'b0;
        model_reset();
        #1 check_en = 1'b1;
        repeat (6) @(posedge clk);
        check_val("midrst_digit0_lit", led_data_packed[7:0], 8'h00);
        tm_clk = 1'b1;
        #T tm_din = 1'b1;
        repeat (4) @(posedge clk);
        #10 rst = 1'b1;
        repeat (6) @(posedge clk);
        frame_q = '{8'h40};
        run_frame(0);
        frame_q = '{8'hC0, 8'h7F};
        run_frame(0);
        check_val("post_rst_digit0_lit", led_data_packed[7:0], 8'h7F);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm_7seg9_rx.md
TM_7SEG9_RX -- requirements
Module: tm_7seg9_rx

Interface
REQ-001 Parameter NUM_DIGITS, default 9: number of display RAM bytes exported on led_data_packed.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the tm_clk/tm_din input synchronizers.
REQ-003 clk  input  1  system clock (10 MHz nominal); all logic is on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low (0 = reset).
REQ-005 tm_clk  input  1  serial bus clock from the display controller; asynchronous to clk.
REQ-006 tm_din  input  1  serial bus data from the display controller; asynchronous to clk.
REQ-007 led_data_packed  output  8*NUM_DIGITS  digit segment RAM; digit n occupies bits [8n+7:8n].
REQ-008 level  output  3  brightness from the last display-control command.
REQ-009 on  output  1  display enable from the last display-control command.
REQ-010 frame_done  output  1  one-cycle pulse after each STOP condition.
REQ-011 err  output  1  one-cycle pulse on any protocol violation.

Function
REQ-012 tm_clk and tm_din shall each pass through SYNC_STAGES flops before use; edges are detected on the synchronized values.
REQ-013 START: synchronized tm_din falls while synchronized tm_clk is 1. STOP: tm_din rises while tm_clk is 1.
REQ-014 Data bits shall be sampled on synchronized tm_clk rising edges, LSB first, 8 bits per byte; no ACK bit.
REQ-015 Operating range: tm_clk high and low phases each >= 3 clk periods; tm_din changes only while tm_clk is 0, except at START/STOP.
REQ-016 FSM states: IDLE, CMD (first byte of frame), DATA (bytes after an address command), SKIP (ignore until STOP).
REQ-017 IDLE -> CMD on START. Any state -> IDLE on STOP. START in any non-IDLE state -> CMD; the partial byte is discarded; no err.
REQ-018 First byte decode on bits[7:6]. 01 = data command: bit2 sets the fixed-address flag (1 fixed, 0 auto-increment). 10 = display control: on = bit3, level = bits[2:0]. 11 = address command: addr = bits[3:0]; go to DATA. 00 = invalid: err; go to SKIP.
REQ-019 After a data or display-control byte, the FSM goes to SKIP. Any further complete byte in SKIP pulses err and is ignored.
REQ-020 In DATA, each complete byte is written to RAM[addr] on the cycle after its 8th bit is sampled. When addr >= NUM_DIGITS, the byte is dropped with no err.
REQ-021 After each DATA byte, addr increments modulo 16 (15 -> 0) unless the fixed-address flag is set.
REQ-022 A STOP with 1..7 bits of a byte collected shall pulse err and discard those bits; 0 bits is legal.
REQ-023 frame_done shall pulse exactly once per STOP, within 2 clk cycles of STOP detection; a STOP seen in IDLE also pulses it.
REQ-024 Simultaneous err and frame_done are allowed on the same cycle.
REQ-025 The fixed-address flag, level and on shall persist across frames until rewritten.

Reset
REQ-026 On rst = 0: led_data_packed = 0, level = 0, on = 0, frame_done = 0, err = 0, addr = 0, fixed flag = 0, bit counter = 0, FSM = IDLE, all synchronizer flops = 1 (bus idle).
REQ-027 Reset mid-frame shall abort the frame; the bus is ignored until the next START after reset release.

Structure
REQ-028 Shared package tm_pkg holds the command-class codes (2'b01, 2'b10, 2'b11), the fixed-address bit index, the FSM state encoding, and default NUM_DIGITS = 9.
REQ-029 One sub-module, tm_sync, shall implement a parameterized synchronizer with rise/fall pulse outputs; it is instantiated once each for tm_clk and tm_din.
REQ-030 The pairing ctl_7seg9 -> tm_7seg9_rx is the loopback bench model; the receiver has no dependency on ctl_7seg9.

Verification
REQ-031 Frames 0x40 | 0xC0, 0x3F, 0x06, ..., 9 bytes -> led_data_packed[7:0] = 0x3F, [15:8] = 0x06, ...; one frame_done per frame; err never asserted.
REQ-032 Frames 0x44 | 0xC3, 0x11, 0x22 -> RAM[3] = 0x22; RAM[4] unchanged.
REQ-033 Frame 0x8C -> on = 1, level = 4; later frame 0x80 -> on = 0, level = 0.
REQ-034 Frames 0x40 | 0xCF, 0xAA, 0x55 -> addr wraps from 15 to 0; RAM[0] = 0x55; no err.
REQ-035 Frame 0x00 -> err pulses once, no state change. Frame 0xC1 with STOP after 4 bits of the next byte -> err pulses; RAM[1] unchanged.
REQ-036 Drive rst low mid-byte, then run a full frame 0x40 | 0xC0, 0x7F -> all outputs zero during reset; RAM[0] = 0x7F after the frame.
